// File: rtl/lap_timer.sv
// lap_timer: BCD stopwatch/countdown (MM:SS.t) with run/pause/done control
// and a valid/ready FIFO of captured lap times.
module lap_timer #(
  parameter int TICK_DIV  = 10,
  parameter int MIN_LIMIT = 59,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           lap,
  input  logic                           down,
  input  logic                           load,
  input  logic [19:0]                    load_val,
  output logic [19:0]                    time_out,
  output logic                           running,
  output logic                           done,
  output logic                           lap_valid,
  input  logic                           lap_ready,
  output logic [19:0]                    lap_data,
  output logic [$clog2(LAP_DEPTH):0]     lap_count,
  output logic                           lap_ovf
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] LIM10 = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM1  = 4'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t         state_q, state_d;
  logic [19:0]    time_q, time_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           dir_q, dir_d;
  logic           done_q, done_d;
  logic [19:0]    mem_q [LAP_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic           ovf_q;

  logic [3:0] m10, m1, s10, s1, ms;
  logic [3:0] m10_n, m1_n, s10_n, s1_n, ms_n;
  logic       up, ms_c, s1_c, s10_c, m_top, m1_w;
  logic [19:0] time_nx;
  logic [6:0] lv_min;
  logic       load_ok, tick, push_req, push, pop, full;

  assign {m10, m1, s10, s1, ms} = time_q;
  assign up = !dir_q;

  // Cascaded BCD carry/borrow: each digit moves only when all lower digits roll.
  assign ms_c  = up ? ms == 4'd9 : ms == 4'd0;
  assign ms_n  = up ? (ms_c ? 4'd0 : ms + 4'd1) : (ms_c ? 4'd9 : ms - 4'd1);
  assign s1_c  = ms_c && (up ? s1 == 4'd9 : s1 == 4'd0);
  assign s1_n  = !ms_c ? s1 : up ? (s1 == 4'd9 ? 4'd0 : s1 + 4'd1) : (s1 == 4'd0 ? 4'd9 : s1 - 4'd1);
  assign s10_c = s1_c && (up ? s10 == 4'd5 : s10 == 4'd0);
  assign s10_n = !s1_c ? s10 : up ? (s10 == 4'd5 ? 4'd0 : s10 + 4'd1) : (s10 == 4'd0 ? 4'd5 : s10 - 4'd1);
  assign m_top = up ? {m10, m1} == {LIM10, LIM1} : {m10, m1} == 8'h00;
  assign m1_w  = up ? m1 == 4'd9 : m1 == 4'd0;
  assign {m10_n, m1_n} = !s10_c ? {m10, m1} :
                         m_top ? (up ? 8'h00 : {LIM10, LIM1}) :
                         up ? (m1_w ? {m10 + 4'd1, 4'd0} : {m10, m1 + 4'd1}) :
                              (m1_w ? {m10 - 4'd1, 4'd9} : {m10, m1 - 4'd1});
  assign time_nx = {m10_n, m1_n, s10_n, s1_n, ms_n};

  assign lv_min  = 7'(load_val[19:16]) * 7'd10 + 7'(load_val[15:12]);
  assign load_ok = load && load_val[19:16] <= 4'd9 && load_val[15:12] <= 4'd9 &&
                   load_val[11:8] <= 4'd5 && load_val[7:4] <= 4'd9 &&
                   load_val[3:0] <= 4'd9 && lv_min <= 7'(MIN_LIMIT);

  assign tick = state_q == RUN && presc_q == PW'(TICK_DIV - 1);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_ok) time_d = load_val;
        if (start && !stop && !(down && time_q == 20'h0)) begin
          state_d = RUN;
          dir_d   = down;
          presc_d = '0;
        end
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) time_d = time_nx;
        // Expiry takes precedence over a same-cycle stop so done is never lost.
        if (tick && dir_q && time_nx == 20'h0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (load_ok) time_d = load_val;
        if (stop) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (start) state_d = RUN;
      end
      DONE: state_d = (start || stop) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  assign push_req = lap && (state_q == RUN || state_q == PAUSE);
  assign pop      = lap_valid && lap_ready;
  assign full     = cnt_q == CW'(LAP_DEPTH);
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      time_q  <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wr_q    <= push ? wr_q + AW'(1) : wr_q;
      rd_q    <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      ovf_q   <= ovf_q || (push_req && full && !pop);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_n && push) mem_q[wr_q] <= time_q;
  end

  assign time_out  = time_q;
  assign running   = state_q == RUN;
  assign done      = done_q;
  assign lap_valid = cnt_q != '0;
  assign lap_data  = mem_q[rd_q];
  assign lap_count = cnt_q;
  assign lap_ovf   = ovf_q;
endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: table-driven directed vectors plus hand-written FIFO and
// countdown sequences for lap_timer (TICK_DIV=2, MIN_LIMIT=1, LAP_DEPTH=4).
module tb_lap_timer;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0, start = 1'b0, stop = 1'b0, lap = 1'b0;
  logic        down = 1'b0, load = 1'b0, lap_ready = 1'b0;
  logic [19:0] load_val = '0;
  logic [19:0] time_out, lap_data;
  logic        running, done, lap_valid, lap_ovf;
  logic [2:0]  lap_count;

  always #5 clk = ~clk;

  lap_timer #(.TICK_DIV(2), .MIN_LIMIT(1), .LAP_DEPTH(4)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .lap(lap),
    .down(down), .load(load), .load_val(load_val), .time_out(time_out),
    .running(running), .done(done), .lap_valid(lap_valid),
    .lap_ready(lap_ready), .lap_data(lap_data), .lap_count(lap_count),
    .lap_ovf(lap_ovf)
  );

  typedef struct {
    logic clr, st, sp, lp, dn, ld, rdy;
    logic [19:0] lv;
    int idle;
    logic [19:0] et;
    logic er, edn;
    logic [2:0] ec;
    logic ev, eo;
    logic [19:0] edat;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic clr, logic st, logic sp, logic lp, logic dn,
                              logic ld, logic [19:0] lv, logic rdy, int idle,
                              logic [19:0] et, logic er, logic edn, logic [2:0] ec,
                              logic ev, logic eo, logic [19:0] edat);
    vec_t v;
    v.clr = clr; v.st = st; v.sp = sp; v.lp = lp; v.dn = dn; v.ld = ld;
    v.lv = lv; v.rdy = rdy; v.idle = idle; v.et = et; v.er = er; v.edn = edn;
    v.ec = ec; v.ev = ev; v.eo = eo; v.edat = edat;
    return v;
  endfunction

  task automatic chk(input string n, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] pops [4];
    int dn_cnt, first;
    //             clr st sp lp dn ld lv        rdy idle et        er ed ec  ev eo edat
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00000, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 20'h00000, 0, 40, 20'h00020, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 20'h00000, 0, 0,  20'h00020, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 20'h00000, 0, 0,  20'h00000, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 20'h01598, 0, 0,  20'h01598, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h01598, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 3,  20'h00000, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 1,  20'h00001, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 20'h00000, 0, 0,  20'h00001, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 20'h02000, 0, 0,  20'h00001, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 20'h00600, 0, 0,  20'h00001, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 20'h00123, 0, 0,  20'h00123, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 20'h00000, 0, 0,  20'h00000, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 20'h00002, 0, 0,  20'h00002, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 20'h00000, 0, 0,  20'h00002, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 1,  20'h00001, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00001, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00000, 0, 1, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00000, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00000, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 1, 0, 20'h00000, 0, 0,  20'h00000, 0, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00000, 1, 0, 0, 0, 0, 20'h0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 20'h00000, 0, 1,  20'h00001, 1, 0, 1, 1, 0, 20'h00000));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 20'h00000, 0, 1,  20'h00002, 1, 0, 2, 1, 0, 20'h00000));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 20'h00000, 0, 1,  20'h00003, 1, 0, 3, 1, 0, 20'h00000));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 20'h00000, 0, 1,  20'h00004, 1, 0, 4, 1, 0, 20'h00000));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 20'h00000, 0, 1,  20'h00005, 1, 0, 4, 1, 1, 20'h00000));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 20'h00123, 0, 0,  20'h00005, 1, 0, 4, 1, 1, 20'h00000));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 1, 0,  20'h00006, 1, 0, 3, 1, 1, 20'h00001));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 1, 0,  20'h00006, 1, 0, 2, 1, 1, 20'h00002));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 1, 0,  20'h00007, 1, 0, 1, 1, 1, 20'h00003));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 1, 0,  20'h00007, 1, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00008, 1, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 20'h00000, 0, 0,  20'h00008, 0, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 9,  20'h00008, 0, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00008, 1, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00009, 1, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 1, 1, 0, 0, 0, 20'h00000, 0, 0,  20'h00009, 0, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 20'h00000, 0, 0,  20'h00009, 1, 0, 0, 0, 1, 20'h0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 20'h00000, 0, 1,  20'h00010, 1, 0, 1, 1, 1, 20'h00009));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 20'h00000, 0, 0,  20'h00011, 1, 0, 2, 1, 1, 20'h00009));
    tv.push_back(mk(0, 1, 0, 1, 0, 0, 20'h00000, 0, 0,  20'h00000, 0, 0, 0, 0, 0, 20'h0));

    for (int i = 0; i < tv.size(); i++) begin
      clr_n = tv[i].clr; start = tv[i].st; stop = tv[i].sp; lap = tv[i].lp;
      down = tv[i].dn; load = tv[i].ld; load_val = tv[i].lv; lap_ready = tv[i].rdy;
      cyc();
      clr_n = 1'b1; start = 1'b0; stop = 1'b0; lap = 1'b0; load = 1'b0;
      repeat (tv[i].idle) cyc();
      chk($sformatf("r%0d time", i), time_out, tv[i].et);
      chk($sformatf("r%0d running", i), 20'(running), 20'(tv[i].er));
      chk($sformatf("r%0d done", i), 20'(done), 20'(tv[i].edn));
      chk($sformatf("r%0d lap_count", i), 20'(lap_count), 20'(tv[i].ec));
      chk($sformatf("r%0d lap_valid", i), 20'(lap_valid), 20'(tv[i].ev));
      chk($sformatf("r%0d lap_ovf", i), 20'(lap_ovf), 20'(tv[i].eo));
      if (tv[i].ev) chk($sformatf("r%0d lap_data", i), lap_data, tv[i].edat);
    end
    lap_ready = 1'b0;

    // Fill the FIFO, then push and pop together while full.
    start = 1'b1; down = 1'b0; cyc(); start = 1'b0;
    lap = 1'b1; repeat (4) cyc();
    lap_ready = 1'b1; cyc(); lap = 1'b0;
    chk("full push+pop count", 20'(lap_count), 20'd4);
    chk("full push+pop ovf", 20'(lap_ovf), 20'd0);
    pops[0] = 20'h00000; pops[1] = 20'h00001; pops[2] = 20'h00001; pops[3] = 20'h00002;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain %0d data", k), lap_data, pops[k]);
      cyc();
    end
    chk("drain lap_valid", 20'(lap_valid), 20'd0);
    lap_ready = 1'b0;

    // Countdown from 00:00.3 with a bounded wait for the done pulse.
    stop = 1'b1; cyc(); cyc(); stop = 1'b0;
    chk("stop twice time", time_out, 20'h00000);
    load_val = 20'h00003; load = 1'b1; cyc(); load = 1'b0;
    down = 1'b1; start = 1'b1; cyc(); start = 1'b0; down = 1'b0;
    dn_cnt = 0; first = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (done) begin
        dn_cnt++;
        if (first == 0) first = k;
      end
    end
    chk("done pulses", 20'(dn_cnt), 20'd1);
    chk("done latency", 20'(first), 20'd6);
    chk("expired time", time_out, 20'h00000);
    chk("expired running", 20'(running), 20'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter TICK_DIV, default 10, SHALL set the number of clk cycles per 100 ms count tick (TICK_DIV >= 1).
REQ-002 Parameter MIN_LIMIT, default 59, SHALL set the highest minute value reached before wrap (range 1..99).
REQ-003 Parameter LAP_DEPTH, default 4, SHALL set the lap FIFO entry count (power of 2, >= 2).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 clr_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 start  in  1  SHALL be a one-cycle start/resume request.
REQ-007 stop  in  1  SHALL be a one-cycle pause/clear request.
REQ-008 lap  in  1  SHALL be a one-cycle lap-capture request.
REQ-009 down  in  1  SHALL select count direction (1 = down), sampled only on IDLE->RUN.
REQ-010 load  in  1  SHALL request preset of time from load_val.
REQ-011 load_val  in  20  SHALL be BCD {min10,min1,sec10,sec1,ms100}, 4 bits each.
REQ-012 time_out  out  20  SHALL be the current time, same BCD packing.
REQ-013 running  out  1  SHALL be high exactly while state is RUN.
REQ-014 done  out  1  SHALL be a one-cycle pulse on countdown expiry.
REQ-015 lap_valid  out  1, lap_ready  in  1, lap_data  out  20 SHALL form a valid/ready lap-FIFO read port.
REQ-016 lap_count  out  clog2(LAP_DEPTH)+1  SHALL be the FIFO occupancy.
REQ-017 lap_ovf  out  1  SHALL be a sticky lap-overflow flag.

Function
REQ-018 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-019 Transitions: IDLE-start->RUN; RUN-stop->PAUSE; PAUSE-start->RUN; PAUSE-stop->IDLE with time cleared to 00:00.0; DONE-start or stop->IDLE.
REQ-020 start and stop in the same cycle: stop SHALL win.
REQ-021 IDLE-start with down=1 and time 00:00.0 SHALL be ignored (stay IDLE).
REQ-022 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, clear to 0 on IDLE->RUN, hold its value in PAUSE; tick = prescaler at TICK_DIV-1 in RUN.
REQ-023 Up count per tick: ms100 0..9, sec1 0..9, sec10 0..5, minutes (min10,min1) 0..MIN_LIMIT; tick at MIN_LIMIT:59.9 SHALL wrap to 00:00.0, FSM stays RUN.
REQ-024 Down count per tick: BCD decrement with the same digit limits; tick producing 00:00.0 SHALL move FSM to DONE; done high for exactly the following cycle; time holds 00:00.0 in DONE.
REQ-025 load SHALL be accepted only in IDLE or PAUSE; ignored in RUN and DONE.
REQ-026 load SHALL be ignored entirely if any digit >9, sec10 >5, or minutes >MIN_LIMIT.
REQ-027 lap in RUN or PAUSE SHALL push time_out as registered before that cycle's update; lap in IDLE/DONE ignored.
REQ-028 Push when full with no pop SHALL be dropped and set lap_ovf; lap_ovf clears only by reset.
REQ-029 lap_valid = FIFO not empty; lap_data = oldest entry; pop on lap_valid & lap_ready.
REQ-030 Push and pop in the same cycle (including full) SHALL both take effect; lap_count unchanged.
REQ-031 Output latency: time_out, running, lap_count SHALL reflect a tick/command on the clock edge that processes it (registered, one cycle).

Reset
REQ-032 clr_n low at a rising edge SHALL force IDLE, time_out 0, prescaler 0, FIFO empty, lap_count 0, lap_valid 0, lap_ovf 0, done 0, running 0, overriding all other inputs.

Verification (TICK_DIV=2, MIN_LIMIT=1, LAP_DEPTH=4)
REQ-033 Up: reset, start, 40 cycles -> time_out 00:02.0, running 1.
REQ-034 Wrap: IDLE load 01:59.8, start down=0, 2 ticks -> 00:00.0, running 1; load 02:00.0 -> ignored.
REQ-035 Countdown: load 00:00.2, down=1, start, 2 ticks -> time 00:00.0, DONE, done one cycle, running 0; next start -> IDLE.
REQ-036 Laps: 5 lap pulses in RUN, lap_ready=0 -> lap_count 4, lap_ovf 1; then lap_ready=1 -> four pops, oldest first, lap_valid 0 after.
REQ-037 Pause: stop mid-prescale, wait 10 cycles -> time unchanged; start -> resumes with held prescaler; start+stop same cycle in RUN -> PAUSE.
REQ-038 Reset mid-run with lap_count 2 -> next edge all outputs at REQ-032 values.
